// File: rtl/inst_mem_loader.sv
// inst_mem_loader: instruction memory with 1-clk read port and a byte-stream program loader
module inst_mem_loader #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] inst_addr,
  output logic [XLEN-1:0]   inst_data,
  input  logic              ld_start,
  input  logic [AWIDTH-1:0] ld_base,
  input  logic [AWIDTH:0]   ld_len,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              core_hold
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
  state_t state_q, state_d;
  logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [AWIDTH:0] wr_cnt_q, wr_cnt_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [XLEN-1:0] buf_q, buf_d, inst_data_q;
  logic done_q, done_d, start, load, accept, last;
  logic [XLEN-1:0] mem [2**AWIDTH];
  always_comb begin
    start = state_q == IDLE && ld_start;
    load = start && ld_len != '0;
    accept = state_q == LOAD && ld_valid;
    last = wr_cnt_q == (AWIDTH+1)'(1);
    state_d = load ? LOAD
            : accept && byte_idx_q == 2'd3 ? WRITE
            : state_q == WRITE ? (last ? IDLE : LOAD)
            : state_q;
    wr_addr_d = load ? ld_base : state_q == WRITE ? wr_addr_q + 1'b1 : wr_addr_q;
    wr_cnt_d = load ? ld_len : state_q == WRITE ? wr_cnt_q - 1'b1 : wr_cnt_q;
    byte_idx_d = load ? 2'd0 : accept ? byte_idx_q + 2'd1 : byte_idx_q;
    buf_d = buf_q;
    if (accept) buf_d[8*byte_idx_q +: 8] = ld_byte;
    done_d = (start && ld_len == '0) || (state_q == WRITE && last);
    ld_ready = state_q == LOAD;
    core_hold = state_q != IDLE;
    ld_done = done_q;
    inst_data = inst_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_addr_q <= '0;
      wr_cnt_q <= '0;
      byte_idx_q <= '0;
      buf_q <= '0;
      done_q <= 1'b0;
      inst_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_cnt_q <= wr_cnt_d;
      byte_idx_q <= byte_idx_d;
      buf_q <= buf_d;
      done_q <= done_d;
      inst_data_q <= mem[inst_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && state_q == WRITE) mem[wr_addr_q] <= buf_q;
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: self-checking bench for inst_mem_loader against a word-level memory model
module tb_inst_mem_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic ld_start = 1'b0;
  logic [9:0] ld_base = '0;
  logic [10:0] ld_len = '0;
  logic [7:0] ld_byte = '0;
  logic ld_valid = 1'b0;
  logic ld_ready, ld_done, core_hold;
  int errors = 0;
  int checks = 0;
  logic [31:0] ref_mem [1024];
  bit known [1024];
  logic [31:0] wq [$];
  typedef struct {
    logic [9:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [10];
  inst_mem_loader #(.XLEN(32), .AWIDTH(10)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len), .ld_byte(ld_byte),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_done(ld_done), .core_hold(core_hold)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic noise_drive(input bit noise);
    ld_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    ld_base = noise ? 10'd0 : ld_base;
    ld_len = noise ? 11'($urandom) : ld_len;
  endtask
  task automatic do_load(input logic [9:0] base, input logic [10:0] len, input int bub,
                         input bit noise, input int coll);
    logic [31:0] w;
    logic [9:0] a;
    int nb;
    ld_start = 1'b1;
    ld_base = base;
    ld_len = len;
    ld_valid = 1'b0;
    step();
    ld_start = 1'b0;
    if (len == 0) begin
      chk("zlen_done", 32'(ld_done), 1);
      chk("zlen_hold", 32'(core_hold), 0);
      chk("zlen_ready", 32'(ld_ready), 0);
      step();
      chk("zlen_done_clr", 32'(ld_done), 0);
      chk("zlen_hold_after", 32'(core_hold), 0);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      w = (wq.size() != 0) ? wq.pop_front() : $urandom;
      a = base + 10'(i);
      for (int b = 0; b < 4; b++) begin
        nb = bub == 1 ? 1 : bub == 2 ? int'($urandom_range(0, 2)) : 0;
        for (int k = 0; k < nb; k++) begin
          ld_valid = 1'b0;
          noise_drive(noise);
          chk("bubble_ready", 32'(ld_ready), 1);
          chk("bubble_hold", 32'(core_hold), 1);
          step();
        end
        chk("load_ready", 32'(ld_ready), 1);
        chk("load_hold", 32'(core_hold), 1);
        chk("load_done", 32'(ld_done), 0);
        ld_valid = 1'b1;
        ld_byte = w[8*b +: 8];
        noise_drive(noise);
        step();
      end
      ld_valid = 1'b0;
      noise_drive(noise);
      chk("write_ready", 32'(ld_ready), 0);
      chk("write_hold", 32'(core_hold), 1);
      chk("write_done", 32'(ld_done), 0);
      if (coll == i) inst_addr = a;
      step();
      if (coll == i) chk("read_first_old", inst_data, ref_mem[a]);
      ref_mem[a] = w;
      known[a] = 1'b1;
    end
    ld_start = 1'b0;
    chk("done_pulse", 32'(ld_done), 1);
    chk("done_hold", 32'(core_hold), 0);
    chk("done_ready", 32'(ld_ready), 0);
    step();
    chk("done_clear", 32'(ld_done), 0);
  endtask
  task automatic rd(input string name, input logic [9:0] a, input logic [31:0] exp);
    inst_addr = a;
    step();
    chk(name, inst_data, exp);
  endtask
  initial begin
    logic [31:0] f0, f1;
    vecs[0] = '{10'h005, 32'hDEADBEEF};
    vecs[1] = '{10'h004, 32'h11111111};
    vecs[2] = '{10'h010, 32'h00000013};
    vecs[3] = '{10'h011, 32'h00100093};
    vecs[4] = '{10'h020, 32'hA0A1A2A3};
    vecs[5] = '{10'h021, 32'hB0B1B2B3};
    vecs[6] = '{10'h022, 32'hC0C1C2C3};
    vecs[7] = '{10'h3FF, 32'h12345678};
    vecs[8] = '{10'h000, 32'h9ABCDEF0};
    vecs[9] = '{10'h100, 32'h55AA55AA};
    step();
    step();
    chk("rst_inst_data", inst_data, 0);
    chk("rst_ready", 32'(ld_ready), 0);
    chk("rst_done", 32'(ld_done), 0);
    chk("rst_hold", 32'(core_hold), 0);
    rst = 1'b0;
    step();
    wq = '{32'hDEADBEEF};
    do_load(10'h005, 11'd1, 0, 1'b0, -1);
    wq = '{32'h11111111};
    do_load(10'h004, 11'd1, 0, 1'b0, -1);
    rd("lat_prev", 10'h004, 32'h11111111);
    inst_addr = 10'h005;
    chk("lat_not_same_cycle", inst_data, 32'h11111111);
    step();
    chk("lat_next_cycle", inst_data, 32'hDEADBEEF);
    wq = '{32'h00000013, 32'h00100093};
    do_load(10'h010, 11'd2, 0, 1'b0, -1);
    wq = '{32'hC0C1C2C3};
    do_load(10'h022, 11'd1, 0, 1'b0, -1);
    wq = '{32'h9ABCDEF0};
    do_load(10'h000, 11'd1, 0, 1'b0, -1);
    wq = '{32'h55AA55AA};
    do_load(10'h100, 11'd1, 0, 1'b0, -1);
    wq = '{32'h12345678, 32'h9ABCDEF0};
    do_load(10'h3FF, 11'd2, 0, 1'b0, -1);
    wq = '{32'hA0A1A2A3, 32'hB0B1B2B3};
    do_load(10'h020, 11'd2, 1, 1'b1, -1);
    do_load(10'h100, 11'd0, 0, 1'b0, -1);
    for (int i = 0; i < 10; i++) rd("vec", vecs[i].addr, vecs[i].exp);
    wq = '{32'hCAFEF00D, 32'h0BADC0DE};
    do_load(10'h010, 11'd2, 0, 1'b0, 0);
    rd("read_first_new", 10'h010, 32'hCAFEF00D);
    wq = '{32'hE0E0E0E0, 32'hE1E1E1E1};
    do_load(10'h030, 11'd2, 0, 1'b0, -1);
    f0 = 32'hF0F1F2F3;
    f1 = 32'hF4F5F6F7;
    ld_start = 1'b1;
    ld_base = 10'h030;
    ld_len = 11'd2;
    step();
    ld_start = 1'b0;
    for (int b = 0; b < 6; b++) begin
      ld_valid = 1'b1;
      ld_byte = b < 4 ? f0[8*b +: 8] : f1[8*(b-4) +: 8];
      step();
      if (b == 3) begin
        ld_valid = 1'b0;
        step();
      end
    end
    ld_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_inst_data", inst_data, 0);
    chk("midrst_ready", 32'(ld_ready), 0);
    chk("midrst_done", 32'(ld_done), 0);
    chk("midrst_hold", 32'(core_hold), 0);
    ref_mem[10'h030] = f0;
    step();
    chk("midrst_no_done", 32'(ld_done), 0);
    rd("midrst_word0", 10'h030, f0);
    rd("midrst_word1", 10'h031, 32'hE1E1E1E1);
    wq = '{32'h76543210};
    do_load(10'h031, 11'd1, 2, 1'b0, -1);
    rd("postrst_load", 10'h031, 32'h76543210);
    for (int n = 0; n < 10; n++)
      do_load(10'($urandom), 11'($urandom_range(0, 4)), 2, 1'($urandom_range(0, 1)), -1);
    for (int a = 0; a < 1024; a++)
      if (known[a]) rd("sweep", 10'(a), ref_mem[a]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
